// File: rtl/uart_pkg.sv
// Shared types and constants for the byte-level UART.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package uart_pkg;

  // One state set serves both the TX and RX frame FSMs.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_BITS  = 8;

  // Clock cycles per oversample tick, rounded down.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick divider: one-cycle tick every DIV clocks.
// Latency: first tick DIV cycles after reset or clr.
// Backpressure: none; free-running unless clr restarts the count.
module uart_baud_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Count 0..DIV-1, tick on the wrap; clr restarts the phase at zero.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == CW'(DIV - 1)) begin
      cnt_d = '0;
      tick  = 1'b1;
    end
    if (clr) begin
      cnt_d = '0;
      tick  = 1'b0;
    end
  end

  // Divider state register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_peripheral.sv
// 8N1 UART byte transmitter/receiver for the core's memory-mapped I/O.
// Latency: TX busy 10 bit times from accept; RX byte visible the edge after mid-stop sample.
// Backpressure: tx_en ignored while tx_status=0; unread RX byte is overwritten (rx_overrun).
module uart_peripheral #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       tx_status,
  output logic [7:0] rx_data,
  output logic       rx_eff,
  input  logic       rx_read,
  output logic       rx_ferr,
  output logic       rx_overrun,
  output logic       uart_tx,
  input  logic       uart_rx
);
  import uart_pkg::*;

  localparam int         DIV       = calc_div(CLK_FREQ, BAUD);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  logic rx_tick, tx_tick, tx_accept;

  // RX samples on a free-running phase; TX restarts its phase on accept so
  // the start bit is always a full bit time long.
  uart_baud_gen #(.DIV(DIV)) u_rx_baud (
    .clk(clk), .reset(reset), .clr(1'b0), .tick(rx_tick)
  );
  uart_baud_gen #(.DIV(DIV)) u_tx_baud (
    .clk(clk), .reset(reset), .clr(tx_accept), .tick(tx_tick)
  );

  // ---------------- TX ----------------
  uart_state_e tx_state_q, tx_state_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [3:0]  tx_cnt_q, tx_cnt_d;

  // TX next state: accept in IDLE, then 16 ticks per start/data/stop bit.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_cnt_d   = tx_cnt_q;
    tx_accept  = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        if (tx_en) begin
          tx_accept  = 1'b1;
          tx_shift_d = tx_data;
          tx_bit_d   = '0;
          tx_cnt_d   = '0;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_tick) begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q == LAST_TICK) tx_state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_tick) begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q == LAST_TICK) begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
            if (tx_bit_q == LAST_BIT) tx_state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tx_tick) begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q == LAST_TICK) tx_state_d = ST_IDLE;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // Serial line level decoded from the TX state; idle and stop are high.
  always_comb begin
    uart_tx = 1'b1;
    case (tx_state_q)
      ST_START: uart_tx = 1'b0;
      ST_DATA:  uart_tx = tx_shift_q[0];
      default:  uart_tx = 1'b1;
    endcase
  end

  assign tx_status = (tx_state_q == ST_IDLE);

  // TX state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= ST_IDLE;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  // ---------------- RX ----------------
  logic        rx_meta_q, rx_sync_q;
  uart_state_e rx_state_q, rx_state_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [3:0]  rx_cnt_q, rx_cnt_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_eff_q, rx_eff_d;
  logic        rx_ferr_q, rx_ferr_d;
  logic        rx_ovr_q, rx_ovr_d;

  // RX next state: start detect, mid-start glitch filter, 16-tick bit sampling.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_cnt_d   = rx_cnt_q;
    rx_data_d  = rx_data_q;
    rx_eff_d   = rx_eff_q & ~rx_read;
    rx_ferr_d  = 1'b0;
    rx_ovr_d   = 1'b0;
    if (rx_tick) begin
      case (rx_state_q)
        ST_IDLE: begin
          if (!rx_sync_q) begin
            rx_state_d = ST_START;
            rx_cnt_d   = '0;
          end
        end
        ST_START: begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == MID_TICK) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == LAST_TICK) begin
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == LAST_BIT) rx_state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == LAST_TICK) begin
            rx_state_d = ST_IDLE;
            if (rx_sync_q) begin
              rx_data_d = rx_shift_q;
              rx_eff_d  = 1'b1;
              rx_ovr_d  = rx_eff_q & ~rx_read;
            end else begin
              rx_ferr_d = 1'b1;
            end
          end
        end
        default: rx_state_d = ST_IDLE;
      endcase
    end
  end

  // RX synchronizer, FSM and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
      rx_cnt_q   <= '0;
      rx_data_q  <= '0;
      rx_eff_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_eff_q   <= rx_eff_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_eff     = rx_eff_q;
  assign rx_ferr    = rx_ferr_q;
  assign rx_overrun = rx_ovr_q;

endmodule

// File: tb/tb_uart_peripheral.sv
// Directed bench for uart_peripheral with DIV=4 (one bit = 64 cycles).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_peripheral;

  localparam int CLK_FREQ = 640000;
  localparam int BAUD     = 10000;
  localparam int DIVN     = 4;
  localparam int BITC     = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_status;
  logic [7:0] rx_data;
  logic       rx_eff;
  logic       rx_read;
  logic       rx_ferr;
  logic       rx_overrun;
  logic       uart_tx;
  logic       rx_line;
  logic       rx_drv;
  logic       loopback;

  int errors = 0;
  int checks = 0;
  int cc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;

  logic [7:0] rx_q[$];
  logic       tx_bits[$];

  always #5 clk = ~clk;

  assign rx_line = loopback ? uart_tx : rx_drv;

  uart_peripheral #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_en(tx_en), .tx_status(tx_status),
    .rx_data(rx_data), .rx_eff(rx_eff), .rx_read(rx_read),
    .rx_ferr(rx_ferr), .rx_overrun(rx_overrun),
    .uart_tx(uart_tx), .uart_rx(rx_line)
  );

  // Cycles since the last reset edge: equals the free-running divider phase.
  always @(posedge clk) begin
    if (reset) cc <= 0;
    else       cc <= cc + 1;
  end

  // Pulse counters for the one-cycle error flags.
  always @(posedge clk) begin
    if (rx_ferr)    ferr_cnt <= ferr_cnt + 1;
    if (rx_overrun) ovr_cnt  <= ovr_cnt + 1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Drive one frame on the RX line, aligned so the synchronized start edge
  // lands on an RX tick; the stop-bit sample then falls on frame cycle 610.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int read_at);
    logic [9:0] fr;
    int guard;
    fr = {stop_bit, d, 1'b0};
    guard = 0;
    while (((cc % DIVN) != 1) && (guard < 8)) begin
      @(negedge clk);
      guard++;
    end
    for (int c = 0; c < 10 * BITC; c++) begin
      rx_drv  = fr[c / BITC];
      rx_read = (c == read_at);
      @(negedge clk);
    end
    rx_drv  = 1'b1;
    rx_read = 1'b0;
  endtask

  initial begin
    logic [9:0] frame;
    logic       exp_bit;
    int f0;
    int o0;

    reset = 1'b1; tx_en = 1'b0; tx_data = 8'h00; rx_read = 1'b0;
    rx_drv = 1'b1; loopback = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of a transmit.
    tx_data = 8'hA5; tx_en = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    repeat (50) @(negedge clk);
    check("busy_before_reset", 8'(tx_status), 8'h00);
    check("line_low_before_reset", 8'(uart_tx), 8'h00);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_uart_tx", 8'(uart_tx), 8'h01);
    check("rst_tx_status", 8'(tx_status), 8'h01);
    check("rst_rx_eff", 8'(rx_eff), 8'h00);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_ferr", 8'(rx_ferr), 8'h00);
    check("rst_rx_overrun", 8'(rx_overrun), 8'h00);

    // Transmit 0xA5; a second strobe at cycle 100 must be ignored.
    frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) tx_bits.push_back(frame[k]);
    tx_data = 8'hA5; tx_en = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    check("tx_status_after_accept", 8'(tx_status), 8'h00);
    for (int c = 1; c <= 640; c++) begin
      @(negedge clk);
      tx_en   = (c == 100);
      tx_data = (c == 100) ? 8'h0F : 8'hA5;
      if ((c % BITC) == 32) begin
        exp_bit = tx_bits.pop_front();
        check($sformatf("tx_bit%0d", c / BITC), 8'(uart_tx), 8'(exp_bit));
      end
      if (c == 639) check("tx_status_last_busy", 8'(tx_status), 8'h00);
      if (c == 640) check("tx_status_done", 8'(tx_status), 8'h01);
    end
    tx_en = 1'b0;
    repeat (5) @(negedge clk);

    // Loopback receive of 0x3C, then acknowledge.
    loopback = 1'b1;
    rx_q.push_back(8'h3C);
    tx_data = 8'h3C; tx_en = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    repeat (642) @(negedge clk);
    check("loop_rx_eff", 8'(rx_eff), 8'h01);
    check("loop_rx_data", rx_data, rx_q.pop_front());
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
    check("rx_read_clears", 8'(rx_eff), 8'h00);
    loopback = 1'b0;
    repeat (10) @(negedge clk);

    // Short low glitch on the line.
    f0 = ferr_cnt; o0 = ovr_cnt;
    rx_drv = 1'b0;
    repeat (10) @(negedge clk);
    rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_rx_eff", 8'(rx_eff), 8'h00);
    check("glitch_ferr", 8'(ferr_cnt - f0), 8'h00);
    check("glitch_ovr", 8'(ovr_cnt - o0), 8'h00);

    // Framing error: stop bit low.
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h55, 1'b0, -1);
    repeat (20) @(negedge clk);
    check("ferr_pulses", 8'(ferr_cnt - f0), 8'h01);
    check("ferr_rx_eff", 8'(rx_eff), 8'h00);
    check("ferr_ovr", 8'(ovr_cnt - o0), 8'h00);

    // Overrun: two bytes with no acknowledge.
    o0 = ovr_cnt;
    rx_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1);
    repeat (4) @(negedge clk);
    check("ovr_first_eff", 8'(rx_eff), 8'h01);
    check("ovr_first_data", rx_data, rx_q.pop_front());
    rx_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, -1);
    repeat (4) @(negedge clk);
    check("ovr_second_data", rx_data, rx_q.pop_front());
    check("ovr_second_eff", 8'(rx_eff), 8'h01);
    check("ovr_pulses", 8'(ovr_cnt - o0), 8'h01);

    // Same pair, acknowledge in the cycle the second byte completes.
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
    check("race_pre_clear", 8'(rx_eff), 8'h00);
    rx_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1);
    repeat (4) @(negedge clk);
    check("race_first_data", rx_data, rx_q.pop_front());
    o0 = ovr_cnt;
    rx_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, 610);
    repeat (4) @(negedge clk);
    check("race_rx_eff", 8'(rx_eff), 8'h01);
    check("race_rx_data", rx_data, rx_q.pop_front());
    check("race_no_ovr", 8'(ovr_cnt - o0), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
